instr_issue_scheduler: RTL and testbench
========================================

Name: instr_issue_scheduler

Overview:
- Sits between the control unit's instruction-queue push port and the three execution units: load/store, RAM (DMA) and arithmetic.
- Buffers pushed instructions in an in-order FIFO and expands each entry into 1..SUPERSCALAR_WIDTH copies with strided addresses.
- Dispatches copies one per cycle to the matching unit over valid/ready handshakes.
- Enforces cache-slot hazards between in-flight RAM transfers and later loads/stores.

Parameters:
LOG_DEPTH, 4, log2 of FIFO entry count (DEPTH = 16)
LOG_SUPERSCALAR_WIDTH, 3, log2 of max copies per entry (8)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
queue_we  in  1  push strobe
queue_instr_type  in  2  0 ld_st, 1 ram, 2 arith, 3 loop
queue_arith_instr  in  14  arithmetic fields
queue_ram_instr  in  9  [0] is_write, [1:6] apus, [7:8] cache slot
queue_ld_st_instr  in  10  [0] is_load, [1:3] apu, [4:5] cache slot, [6:9] reg/flags
cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr  in  18 each  base addresses and per-copy strides
queue_copy_cnt  in  LOG_SUPERSCALAR_WIDTH+1  copies; 0 is treated as 1
queue_full  out  1  FIFO full
overflow_err  out  1  sticky: push attempted while full
ld_st_valid / ld_st_ready  out / in  1  load/store handshake
ld_st_instr  out  10  load/store instruction
ld_st_cache_addr  out  18  load/store cache address
ram_valid / ram_ready  out / in  1  RAM handshake
ram_instr  out  9  RAM instruction
ram_cache_addr, ram_main_mem_addr  out  18 each  RAM addresses
arith_valid / arith_ready  out / in  1  arithmetic handshake
arith_instr  out  14  arithmetic instruction
ram_done  in  1  RAM transfer completion pulse
ram_done_slot  in  2  slot of the completed transfer
idle  out  1  FIFO empty and no slot busy

Behaviour:
- Reset (reset_n=0 at edge) clears FIFO pointers, copy counter, slot_busy[3:0] and overflow_err. Any partially issued entry is discarded.
- Outputs after reset: all valids 0, queue_full 0, overflow_err 0, idle 1; data outputs 0.
- Push: on queue_we with type != 3 and not full, store all fields.
  - Type 3 (loop) is silently dropped; the control unit retires loops itself.
  - Push while full: entry dropped, overflow_err set, held until reset.
- Latency: push at edge N makes the entry visible as the head in the cycle after edge N when the FIFO was empty.
- Head issue state: copy index k, 0..cnt-1.
  - Outputs are driven from registered head state only; valid never depends on ready in the same cycle.
  - Only the valid of the head's unit may be high, and only one dispatch occurs per cycle.
- Copy addressing, modulo 2^18:
  - cache address = cache_addr + k*d_cache_addr
  - main address = main_mem_addr + k*d_main_mem_addr
  - Arithmetic copies repeat the instruction unchanged.
- Handshake: a copy transfers on valid&&ready.
  - k increments on transfer. On the last copy (k=cnt-1) the entry pops and k returns to 0.
  - A new head may issue the following cycle.
  - Once valid is raised, payload stays stable until the transfer.
- Hazards on slot_busy:
  - RAM valid requires slot_busy[ram slot]=0. Each RAM copy transfer sets slot_busy[slot].
  - Load/store valid requires slot_busy[ld_st slot]=0.
  - ram_done clears slot_busy[ram_done_slot] at the edge; the stalled head may issue the next cycle.
  - Set and clear on the same slot cannot coincide, because a RAM issue needs the slot clear.
  - Clearing an already-clear slot is a no-op.
- Simultaneous push and pop:
  - Allowed when full, since the pop frees a slot.
  - When empty, the push is not issued in the same cycle.
- Hazard-stall FSM per head: EMPTY -> ISSUE (head present, no hazard) or STALL (hazard).
  - STALL -> ISSUE once the slot clears.
  - ISSUE -> EMPTY on the last pop with the FIFO empty.
- idle = FIFO empty && slot_busy == 0.

Decomposition:
- Shared package holds:
  - instr type enum: INSTR_TYPE_LOAD_STORE=0, INSTR_TYPE_RAM=1, INSTR_TYPE_ARITHMETIC=2, INSTR_TYPE_LOOP=3
  - field widths (14/9/10), address width 18, slot bit positions
- One sub-module: instr_fifo, a parameterised synchronous FIFO with full/empty and a packed entry.
- Copy expansion, hazard logic and FSM live in the top module.

Test Plan:
- Reset, then push ld_st (slot 1, cache_addr=100, d=4, cnt=3) with ld_st_ready=1 -> ld_st_cache_addr 100, 104, 108 on three consecutive cycles; then idle=1.
- Push RAM (slot 2, main_mem_addr=0x3FFFE, d_main=1, cnt=3) -> main addresses 0x3FFFE, 0x3FFFF, 0x00000 (wrap); slot_busy[2]=1.
- Push ld_st on slot 2 after that RAM -> ld_st_valid stays 0; pulse ram_done, slot=2 -> ld_st_valid=1 the next cycle.
- Push arith (cnt=0) with arith_ready toggling 0/1 -> exactly one transfer; arith_instr stable while stalled.
- Push 17 entries with all readies=0 -> queue_full after 16; 17th dropped; overflow_err=1. Push loop type -> FIFO count unchanged.
- Drive reset_n=0 mid-expansion (k=2 of 5) -> all valids 0 the next cycle; FIFO empty; idle=1.

Source files
------------

// File: rtl/instr_issue_scheduler_pkg.sv
// instr_issue_scheduler_pkg: shared types, field widths and slot positions for the issue scheduler
package instr_issue_scheduler_pkg;
  typedef enum logic [1:0] {
    INSTR_TYPE_LOAD_STORE = 2'd0,
    INSTR_TYPE_RAM        = 2'd1,
    INSTR_TYPE_ARITHMETIC = 2'd2,
    INSTR_TYPE_LOOP       = 2'd3
  } instr_type_t;
  localparam int ARITH_W = 14;
  localparam int RAM_W = 9;
  localparam int LD_ST_W = 10;
  localparam int ADDR_W = 18;
  localparam int SLOT_W = 2;
  localparam int NUM_SLOTS = 4;
  localparam int RAM_SLOT_LSB = 7;
  localparam int LD_ST_SLOT_LSB = 4;
  typedef struct packed {
    instr_type_t instr_type;
    logic [ARITH_W-1:0] arith;
    logic [RAM_W-1:0] ram;
    logic [LD_ST_W-1:0] ld_st;
    logic [ADDR_W-1:0] cache_addr;
    logic [ADDR_W-1:0] main_mem_addr;
    logic [ADDR_W-1:0] d_cache_addr;
    logic [ADDR_W-1:0] d_main_mem_addr;
  } entry_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ISSUE, ST_STALL} state_t;
  function automatic logic [ADDR_W-1:0] stride_addr(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] step, input logic [ADDR_W-1:0] k);
    return base + k * step;
  endfunction
endpackage

// File: rtl/instr_issue_scheduler_fifo.sv
// instr_fifo: synchronous FIFO with an extra pointer bit to tell full from empty
module instr_fifo #(
  parameter int W = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] wr, rd;
  assign empty = wr == rd;
  assign full = wr == {~rd[LOG_DEPTH], rd[LOG_DEPTH-1:0]};
  assign dout = mem[rd[LOG_DEPTH-1:0]];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + (LOG_DEPTH+1)'(1);
      if (pop) rd <= rd + (LOG_DEPTH+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr[LOG_DEPTH-1:0]] <= din;
endmodule

// File: rtl/instr_issue_scheduler.sv
// instr_issue_scheduler: buffers instructions, expands strided copies and dispatches them
// to the load/store, RAM and arithmetic units under cache-slot hazards.
module instr_issue_scheduler
  import instr_issue_scheduler_pkg::*;
#(
  parameter int LOG_DEPTH = 4,
  parameter int LOG_SUPERSCALAR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           queue_we,
  input  logic [1:0]                     queue_instr_type,
  input  logic [ARITH_W-1:0]             queue_arith_instr,
  input  logic [RAM_W-1:0]               queue_ram_instr,
  input  logic [LD_ST_W-1:0]             queue_ld_st_instr,
  input  logic [ADDR_W-1:0]              cache_addr,
  input  logic [ADDR_W-1:0]              main_mem_addr,
  input  logic [ADDR_W-1:0]              d_cache_addr,
  input  logic [ADDR_W-1:0]              d_main_mem_addr,
  input  logic [LOG_SUPERSCALAR_WIDTH:0] queue_copy_cnt,
  output logic                           queue_full,
  output logic                           overflow_err,
  output logic                           ld_st_valid,
  input  logic                           ld_st_ready,
  output logic [LD_ST_W-1:0]             ld_st_instr,
  output logic [ADDR_W-1:0]              ld_st_cache_addr,
  output logic                           ram_valid,
  input  logic                           ram_ready,
  output logic [RAM_W-1:0]               ram_instr,
  output logic [ADDR_W-1:0]              ram_cache_addr,
  output logic [ADDR_W-1:0]              ram_main_mem_addr,
  output logic                           arith_valid,
  input  logic                           arith_ready,
  output logic [ARITH_W-1:0]             arith_instr,
  input  logic                           ram_done,
  input  logic [SLOT_W-1:0]              ram_done_slot,
  output logic                           idle
);
  localparam int CW = LOG_SUPERSCALAR_WIDTH + 1;
  entry_t in_e, head;
  state_t state;
  logic [CW-1:0] head_cnt, k, last_k;
  logic [$bits(entry_t)+CW-1:0] fifo_out;
  logic [NUM_SLOTS-1:0] slot_busy, done_mask, set_mask;
  logic [SLOT_W-1:0] ram_slot, ld_slot;
  logic empty, full, push_req, push, pop, xfer, ram_xfer, hazard, is_ld, is_ram, is_arith;
  logic [ADDR_W-1:0] c_addr;
  assign in_e = '{instr_type: instr_type_t'(queue_instr_type), arith: queue_arith_instr,
                  ram: queue_ram_instr, ld_st: queue_ld_st_instr, cache_addr: cache_addr,
                  main_mem_addr: main_mem_addr, d_cache_addr: d_cache_addr,
                  d_main_mem_addr: d_main_mem_addr};
  instr_fifo #(.W($bits(entry_t) + CW), .LOG_DEPTH(LOG_DEPTH)) fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .din({queue_copy_cnt, in_e}), .dout(fifo_out), .full(full), .empty(empty)
  );
  assign {head_cnt, head} = fifo_out;
  assign ram_slot = head.ram[RAM_SLOT_LSB +: SLOT_W];
  assign ld_slot = head.ld_st[LD_ST_SLOT_LSB +: SLOT_W];
  assign is_ld = !empty && head.instr_type == INSTR_TYPE_LOAD_STORE;
  assign is_ram = !empty && head.instr_type == INSTR_TYPE_RAM;
  assign is_arith = !empty && head.instr_type == INSTR_TYPE_ARITHMETIC;
  assign ld_st_valid = is_ld && !slot_busy[ld_slot];
  assign ram_valid = is_ram && !slot_busy[ram_slot];
  assign arith_valid = is_arith;
  assign hazard = (is_ld && slot_busy[ld_slot]) || (is_ram && slot_busy[ram_slot]);
  assign ram_xfer = ram_valid && ram_ready;
  assign xfer = (ld_st_valid && ld_st_ready) || ram_xfer || (arith_valid && arith_ready);
  assign last_k = head_cnt == '0 ? '0 : head_cnt - CW'(1);
  assign pop = xfer && k == last_k;
  assign push_req = queue_we && queue_instr_type != INSTR_TYPE_LOOP;
  assign push = push_req && (!full || pop);
  assign c_addr = stride_addr(head.cache_addr, head.d_cache_addr, ADDR_W'(k));
  assign ld_st_instr = ld_st_valid ? head.ld_st : '0;
  assign ld_st_cache_addr = ld_st_valid ? c_addr : '0;
  assign ram_instr = ram_valid ? head.ram : '0;
  assign ram_cache_addr = ram_valid ? c_addr : '0;
  assign ram_main_mem_addr = ram_valid ? stride_addr(head.main_mem_addr, head.d_main_mem_addr, ADDR_W'(k)) : '0;
  assign arith_instr = arith_valid ? head.arith : '0;
  assign queue_full = full;
  assign idle = empty && slot_busy == '0;
  assign done_mask = ram_done ? NUM_SLOTS'(1) << ram_done_slot : '0;
  assign set_mask = ram_xfer ? NUM_SLOTS'(1) << ram_slot : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k <= '0;
      slot_busy <= '0;
      overflow_err <= 1'b0;
    end else begin
      k <= pop ? '0 : xfer ? k + CW'(1) : k;
      slot_busy <= (slot_busy & ~done_mask) | set_mask;
      overflow_err <= overflow_err | (push_req && full && !pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_EMPTY;
    else
      case (state)
        ST_EMPTY: if (!empty) state <= hazard ? ST_STALL : ST_ISSUE;
        ST_STALL: if (!hazard) state <= ST_ISSUE;
        default:  state <= empty ? ST_EMPTY : hazard ? ST_STALL : ST_ISSUE;
      endcase
  end
endmodule

// File: tb/tb_instr_issue_scheduler.sv
// tb_instr_issue_scheduler: directed and random stimulus checked against a queue-based model
module tb_instr_issue_scheduler;
  logic clk = 0, reset_n = 0, queue_we = 0;
  logic [1:0] queue_instr_type = 0;
  logic [13:0] queue_arith_instr = 0;
  logic [8:0] queue_ram_instr = 0;
  logic [9:0] queue_ld_st_instr = 0;
  logic [17:0] cache_addr = 0, main_mem_addr = 0, d_cache_addr = 0, d_main_mem_addr = 0;
  logic [3:0] queue_copy_cnt = 0;
  logic ld_st_ready = 0, ram_ready = 0, arith_ready = 0, ram_done = 0;
  logic [1:0] ram_done_slot = 0;
  logic queue_full, overflow_err, ld_st_valid, ram_valid, arith_valid, idle;
  logic [9:0] ld_st_instr;
  logic [8:0] ram_instr;
  logic [13:0] arith_instr;
  logic [17:0] ld_st_cache_addr, ram_cache_addr, ram_main_mem_addr;

  always #5 clk = ~clk;

  instr_issue_scheduler dut (
    .clk(clk), .reset_n(reset_n), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
    .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
    .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr), .main_mem_addr(main_mem_addr),
    .d_cache_addr(d_cache_addr), .d_main_mem_addr(d_main_mem_addr), .queue_copy_cnt(queue_copy_cnt),
    .queue_full(queue_full), .overflow_err(overflow_err),
    .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready), .ld_st_instr(ld_st_instr),
    .ld_st_cache_addr(ld_st_cache_addr), .ram_valid(ram_valid), .ram_ready(ram_ready),
    .ram_instr(ram_instr), .ram_cache_addr(ram_cache_addr), .ram_main_mem_addr(ram_main_mem_addr),
    .arith_valid(arith_valid), .arith_ready(arith_ready), .arith_instr(arith_instr),
    .ram_done(ram_done), .ram_done_slot(ram_done_slot), .idle(idle)
  );

  typedef struct {int t; int a; int r; int l; int ca; int ma; int dc; int dm; int cnt;} ent_t;
  ent_t q[$];
  int k;
  bit [3:0] busy;
  bit ovf;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ld(input int slot);
    return (5 << 6) | (slot << 4) | (3 << 1) | 1;
  endfunction
  function automatic int ram(input int slot);
    return (slot << 7) | (6'h15 << 1) | 1;
  endfunction
  function automatic int copies(input int c);
    return c == 0 ? 1 : c;
  endfunction
  function automatic int addr(input int base, input int d);
    return (base + k * d) % 262144;
  endfunction
  function automatic bit exp_lv();
    return q.size() > 0 && q[0].t == 0 && !busy[(q[0].l >> 4) & 3];
  endfunction
  function automatic bit exp_rv();
    return q.size() > 0 && q[0].t == 1 && !busy[(q[0].r >> 7) & 3];
  endfunction
  function automatic bit exp_av();
    return q.size() > 0 && q[0].t == 2;
  endfunction

  task automatic check_outputs();
    chk("ld_st_valid", ld_st_valid, exp_lv());
    chk("ram_valid", ram_valid, exp_rv());
    chk("arith_valid", arith_valid, exp_av());
    chk("queue_full", queue_full, q.size() == 16);
    chk("overflow_err", overflow_err, ovf);
    chk("idle", idle, q.size() == 0 && busy == 0);
    if (exp_lv()) begin
      chk("ld_st_instr", ld_st_instr, q[0].l);
      chk("ld_st_cache_addr", ld_st_cache_addr, addr(q[0].ca, q[0].dc));
    end
    if (exp_rv()) begin
      chk("ram_instr", ram_instr, q[0].r);
      chk("ram_cache_addr", ram_cache_addr, addr(q[0].ca, q[0].dc));
      chk("ram_main_mem_addr", ram_main_mem_addr, addr(q[0].ma, q[0].dm));
    end
    if (exp_av()) chk("arith_instr", arith_instr, q[0].a);
  endtask

  task automatic cyc();
    bit rx, xf, pp, acc;
    ent_t e;
    check_outputs();
    rx = exp_rv() && ram_ready;
    xf = (exp_lv() && ld_st_ready) || rx || (exp_av() && arith_ready);
    pp = 0;
    if (xf) pp = k == copies(q[0].cnt) - 1;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      k = 0;
      busy = 0;
      ovf = 0;
    end else begin
      if (ram_done) busy[ram_done_slot] = 0;
      if (rx) busy[(q[0].r >> 7) & 3] = 1;
      acc = 0;
      if (queue_we && queue_instr_type != 3) begin
        if (q.size() < 16 || pp) acc = 1;
        else ovf = 1;
      end
      e = '{int'(queue_instr_type), int'(queue_arith_instr), int'(queue_ram_instr),
            int'(queue_ld_st_instr), int'(cache_addr), int'(main_mem_addr),
            int'(d_cache_addr), int'(d_main_mem_addr), int'(queue_copy_cnt)};
      if (pp) begin
        void'(q.pop_front());
        k = 0;
      end else if (xf) k++;
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic push(input int t, input int a, input int r, input int l, input int ca,
                      input int ma, input int dc, input int dm, input int cnt);
    queue_we = 1;
    queue_instr_type = 2'(t);
    queue_arith_instr = 14'(a);
    queue_ram_instr = 9'(r);
    queue_ld_st_instr = 10'(l);
    cache_addr = 18'(ca);
    main_mem_addr = 18'(ma);
    d_cache_addr = 18'(dc);
    d_main_mem_addr = 18'(dm);
    queue_copy_cnt = 4'(cnt);
    cyc();
    queue_we = 0;
  endtask

  task automatic done_pulse(input int slot);
    ram_done = 1;
    ram_done_slot = 2'(slot);
    cyc();
    ram_done = 0;
  endtask

  initial begin
    int s;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    chk("rst_ld_st_valid", ld_st_valid, 0);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_arith_valid", arith_valid, 0);
    chk("rst_full", queue_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ld_st_instr", ld_st_instr, 0);
    chk("rst_ld_st_addr", ld_st_cache_addr, 0);
    chk("rst_ram_instr", ram_instr, 0);
    chk("rst_ram_main", ram_main_mem_addr, 0);
    chk("rst_arith_instr", arith_instr, 0);

    ld_st_ready = 1;
    push(0, 0, 0, ld(1), 100, 0, 4, 0, 3);
    chk("ld_addr0", ld_st_cache_addr, 100);
    cyc();
    chk("ld_addr1", ld_st_cache_addr, 104);
    cyc();
    chk("ld_addr2", ld_st_cache_addr, 108);
    cyc();
    chk("ld_done_idle", idle, 1);

    ld_st_ready = 0;
    ram_ready = 1;
    push(1, 0, ram(2), 0, 0, 'h3FFFE, 0, 1, 3);
    chk("ram_main0", ram_main_mem_addr, 'h3FFFE);
    push(0, 0, 0, ld(2), 7, 0, 0, 0, 1);
    chk("ram_slot_stall", ram_valid, 0);
    done_pulse(2);
    chk("ram_main1", ram_main_mem_addr, 'h3FFFF);
    cyc();
    done_pulse(2);
    chk("ram_main_wrap", ram_main_mem_addr, 0);
    cyc();
    chk("ld_hazard", ld_st_valid, 0);
    ld_st_ready = 1;
    cyc();
    chk("ld_hazard_hold", ld_st_valid, 0);
    done_pulse(2);
    chk("ld_released", ld_st_valid, 1);
    cyc();
    ram_ready = 0;
    ld_st_ready = 0;

    push(2, 'h2A5B, 0, 0, 0, 0, 0, 0, 0);
    chk("arith_valid", arith_valid, 1);
    cyc();
    chk("arith_stable", arith_instr, 'h2A5B);
    arith_ready = 1;
    cyc();
    arith_ready = 0;
    chk("arith_one_xfer", arith_valid, 0);
    cyc();

    push(3, 1, 1, 1, 1, 1, 1, 1, 1);
    chk("loop_dropped", idle, 1);
    for (int i = 0; i < 16; i++) push(0, 0, 0, ld(0), i, 0, 1, 0, 1);
    chk("full16", queue_full, 1);
    chk("no_ovf16", overflow_err, 0);
    push(0, 0, 0, ld(0), 99, 0, 1, 0, 1);
    chk("ovf17", overflow_err, 1);
    push(3, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("loop_full", queue_full, 1);
    reset_n = 0;
    cyc();
    reset_n = 1;
    chk("rst2_ovf", overflow_err, 0);
    chk("rst2_full", queue_full, 0);

    ld_st_ready = 1;
    push(0, 0, 0, ld(3), 0, 0, 1, 0, 5);
    cyc();
    cyc();
    chk("mid_k2", ld_st_cache_addr, 2);
    reset_n = 0;
    cyc();
    reset_n = 1;
    chk("mid_rst_ld_valid", ld_st_valid, 0);
    chk("mid_rst_idle", idle, 1);
    cyc();
    chk("mid_rst_quiet", ld_st_valid, 0);

    for (int i = 0; i < 800; i++) begin
      queue_we = $urandom_range(0, 2) == 0;
      queue_instr_type = 2'($urandom_range(0, 3));
      queue_arith_instr = 14'($urandom_range(0, 16383));
      queue_ram_instr = 9'($urandom_range(0, 511));
      queue_ld_st_instr = 10'($urandom_range(0, 1023));
      cache_addr = 18'($urandom_range(0, 262143));
      main_mem_addr = 18'($urandom_range(0, 262143));
      d_cache_addr = 18'($urandom_range(0, 262143));
      d_main_mem_addr = 18'($urandom_range(0, 262143));
      queue_copy_cnt = 4'($urandom_range(0, 8));
      ld_st_ready = $urandom_range(0, 3) != 0;
      ram_ready = $urandom_range(0, 3) != 0;
      arith_ready = $urandom_range(0, 3) != 0;
      ram_done = 0;
      if (busy != 0 && $urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, 3);
        while (!busy[s]) s = (s + 1) % 4;
        ram_done = 1;
        ram_done_slot = 2'(s);
      end
      cyc();
    end
    queue_we = 0;
    ram_done = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
